// File: rtl/nv_nvdla_cdp_wdma_cmd_consumer_if.sv
// CDP WDMA command consumer bus bundle: command pop, data pop and
// DMA write request handshakes.
interface nv_nvdla_cdp_wdma_cmd_consumer_if #(
  parameter int DW = 256
);
  logic          cmd_fifo_rd_pvld;
  logic          cmd_fifo_rd_prdy;
  logic [14:0]   cmd_fifo_rd_pd;
  logic          dat_fifo_rd_pvld;
  logic          dat_fifo_rd_prdy;
  logic [DW-1:0] dat_fifo_rd_pd;
  logic          dma_wr_req_pvld;
  logic          dma_wr_req_prdy;
  logic          dma_wr_req_type;
  logic [DW-1:0] dma_wr_req_pd;

  modport master (
    input  cmd_fifo_rd_pvld,
    input  cmd_fifo_rd_pd,
    output cmd_fifo_rd_prdy,
    input  dat_fifo_rd_pvld,
    input  dat_fifo_rd_pd,
    output dat_fifo_rd_prdy,
    output dma_wr_req_pvld,
    input  dma_wr_req_prdy,
    output dma_wr_req_type,
    output dma_wr_req_pd
  );

  modport slave (
    output cmd_fifo_rd_pvld,
    output cmd_fifo_rd_pd,
    input  cmd_fifo_rd_prdy,
    output dat_fifo_rd_pvld,
    output dat_fifo_rd_pd,
    input  dat_fifo_rd_prdy,
    input  dma_wr_req_pvld,
    output dma_wr_req_prdy,
    input  dma_wr_req_type,
    input  dma_wr_req_pd
  );
endinterface

// File: rtl/nv_nvdla_cdp_wdma_cmd_consumer.sv
// CDP WDMA command consumer: turns each write command into a header
// beat plus size+1 data beats and tracks the surface/line address.
module nv_nvdla_cdp_wdma_cmd_consumer #(
  parameter int AW = 64,
  parameter int DW = 256
) (
  input  logic          nvdla_core_clk_mgated,
  input  logic          nvdla_core_rstn,
  input  logic          op_load,
  input  logic [AW-1:0] reg_base_addr,
  input  logic [AW-1:0] reg_line_stride,
  nv_nvdla_cdp_wdma_cmd_consumer_if.master bus,
  output logic          cube_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t        state;
  logic          cmd_rdy_q;
  logic          hdr_vld_q;
  logic [12:0]   size_q;
  logic          line_end_q;
  logic          cube_end_q;
  logic [12:0]   beat_cnt;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] line_base;

  logic          in_data;
  logic          cmd_pop;
  logic          hdr_acc;
  logic          dat_acc;
  logic [13:0]   size_p1;
  logic [AW-1:0] step_bytes;
  logic [AW-1:0] line_next;
  logic [DW-1:0] hdr_pd;

  assign in_data    = (state == DATA);
  assign cmd_pop    = bus.cmd_fifo_rd_pvld & cmd_rdy_q;
  assign hdr_acc    = hdr_vld_q & bus.dma_wr_req_prdy;
  assign dat_acc    = in_data & bus.dat_fifo_rd_pvld
                    & bus.dma_wr_req_prdy;
  assign size_p1    = {1'b0, size_q} + 14'd1;
  assign step_bytes = {{(AW-19){1'b0}}, size_p1, 5'd0};
  assign line_next  = line_base + reg_line_stride;
  assign hdr_pd     = {{(DW-13-AW){1'b0}}, size_q, cur_addr};

  // cmd_rdy_q/hdr_vld_q mirror IDLE/HDR but stay low while in reset
  assign bus.cmd_fifo_rd_prdy = cmd_rdy_q;
  assign bus.dat_fifo_rd_prdy = in_data & bus.dma_wr_req_prdy;
  assign bus.dma_wr_req_pvld  = hdr_vld_q
                              | (in_data & bus.dat_fifo_rd_pvld);
  assign bus.dma_wr_req_type  = in_data;
  assign bus.dma_wr_req_pd    = in_data   ? bus.dat_fifo_rd_pd :
                                hdr_vld_q ? hdr_pd : '0;

  always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state      <= IDLE;
      cmd_rdy_q  <= 1'b0;
      hdr_vld_q  <= 1'b0;
      size_q     <= '0;
      line_end_q <= 1'b0;
      cube_end_q <= 1'b0;
      beat_cnt   <= '0;
      cur_addr   <= '0;
      line_base  <= '0;
      cube_done  <= 1'b0;
    end else begin
      cube_done <= 1'b0;
      unique case (state)
        IDLE: begin
          cmd_rdy_q <= ~cmd_pop;
          if (op_load) begin
            cur_addr  <= reg_base_addr;
            line_base <= reg_base_addr;
          end
          if (cmd_pop) begin
            size_q     <= bus.cmd_fifo_rd_pd[12:0];
            line_end_q <= bus.cmd_fifo_rd_pd[13];
            cube_end_q <= bus.cmd_fifo_rd_pd[14];
            hdr_vld_q  <= 1'b1;
            state      <= HDR;
          end
        end
        HDR: begin
          if (hdr_acc) begin
            beat_cnt  <= size_q;
            hdr_vld_q <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (dat_acc) begin
            if (beat_cnt != 13'd0) begin
              beat_cnt <= beat_cnt - 13'd1;
            end else begin
              state     <= IDLE;
              cmd_rdy_q <= 1'b1;
              cube_done <= cube_end_q;
              // a finished cube parks the address until the next op_load
              if (!cube_end_q) begin
                if (line_end_q) begin
                  line_base <= line_next;
                  cur_addr  <= line_next;
                end else begin
                  cur_addr <= cur_addr + step_bytes;
                end
              end
            end
          end
        end
        default: begin
          state     <= IDLE;
          cmd_rdy_q <= 1'b0;
          hdr_vld_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nv_nvdla_cdp_wdma_cmd_consumer.sv
// Bench for the CDP WDMA command consumer: queue-based request model
// checked every cycle plus literal address expectations.
module tb_nv_nvdla_cdp_wdma_cmd_consumer;
  localparam int AW = 64;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          op_load = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW-1:0] stride = '0;
  logic          cube_done;

  nv_nvdla_cdp_wdma_cmd_consumer_if #(.DW(DW)) bus ();

  nv_nvdla_cdp_wdma_cmd_consumer #(.AW(AW), .DW(DW)) dut (
    .nvdla_core_clk_mgated (clk),
    .nvdla_core_rstn       (rstn),
    .op_load               (op_load),
    .reg_base_addr         (base),
    .reg_line_stride       (stride),
    .bus                   (bus),
    .cube_done             (cube_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            hdr;
    logic [DW-1:0] pd;
    bit            last_cube;
  } item_t;

  item_t         exp_q[$];
  logic [14:0]   cmd_q[$];
  logic [DW-1:0] dat_q[$];
  logic [AW-1:0] hdr_log[$];

  int total = 0;
  int bad = 0;
  int cd_cnt = 0;
  int dat_acc_cnt = 0;
  bit settled = 0;
  bit stall = 0;
  bit exp_cd = 0;
  bit f_cmd = 0;
  bit f_dat = 0;
  int unsigned dat_ctr = 0;
  logic [AW-1:0] m_cur = '0;
  logic [AW-1:0] m_base = '0;

  task automatic chk1(string nm, logic act, logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%b req=%b", nm, act, req);
    end
  endtask

  task automatic chkw(string nm, logic [DW-1:0] act, logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h", nm, act, req);
    end
  endtask

  task automatic chka(string nm, logic [AW-1:0] act, logic [AW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h", nm, act, req);
    end
  endtask

  task automatic add_cmd(int size, bit le, bit ce);
    cmd_q.push_back({ce, le, 13'(size)});
    for (int i = 0; i <= size; i++) begin
      dat_ctr++;
      dat_q.push_back({8{dat_ctr}});
    end
  endtask

  task automatic drive();
    bus.cmd_fifo_rd_pvld = (cmd_q.size() != 0);
    bus.cmd_fifo_rd_pd   = (cmd_q.size() != 0) ? cmd_q[0] : '0;
    bus.dat_fifo_rd_pvld = (dat_q.size() != 0)
                         && (!stall || $urandom_range(3) != 0);
    bus.dat_fifo_rd_pd   = (dat_q.size() != 0) ? dat_q[0] : '0;
    bus.dma_wr_req_prdy  = !stall || $urandom_range(2) != 0;
  endtask

  // Model: every popped command expands into header + size+1 data items
  task automatic check();
    logic acc, cpop, dpop, idle;
    logic [14:0] c;
    logic [12:0] sz;
    item_t it;
    f_cmd = 0;
    f_dat = 0;
    if (!rstn || !settled) return;
    cpop = bus.cmd_fifo_rd_pvld & bus.cmd_fifo_rd_prdy;
    dpop = bus.dat_fifo_rd_pvld & bus.dat_fifo_rd_prdy;
    acc  = bus.dma_wr_req_pvld & bus.dma_wr_req_prdy;
    idle = (exp_q.size() == 0);
    chk1("cube_done", cube_done, exp_cd);
    if (cube_done) cd_cnt++;
    exp_cd = 0;
    chk1("dat_pop_vs_accept", dpop, acc & bus.dma_wr_req_type);
    if (idle) begin
      chk1("cmd_prdy_idle", bus.cmd_fifo_rd_prdy, 1'b1);
      chk1("req_pvld_idle", bus.dma_wr_req_pvld, 1'b0);
      chk1("dat_prdy_idle", bus.dat_fifo_rd_prdy, 1'b0);
    end else begin
      chk1("cmd_prdy_busy", bus.cmd_fifo_rd_prdy, 1'b0);
      if (exp_q[0].hdr) begin
        chk1("hdr_pvld", bus.dma_wr_req_pvld, 1'b1);
        chk1("hdr_type", bus.dma_wr_req_type, 1'b0);
        chkw("hdr_pd", bus.dma_wr_req_pd, exp_q[0].pd);
        chk1("dat_prdy_hdr", bus.dat_fifo_rd_prdy, 1'b0);
      end else begin
        chk1("dat_prdy_pass", bus.dat_fifo_rd_prdy, bus.dma_wr_req_prdy);
        chk1("dat_pvld_pass", bus.dma_wr_req_pvld, bus.dat_fifo_rd_pvld);
        if (bus.dma_wr_req_pvld) begin
          chk1("dat_type", bus.dma_wr_req_type, 1'b1);
          chkw("dat_pd", bus.dma_wr_req_pd,
               (dat_q.size() != 0) ? dat_q[0] : '0);
        end
      end
    end
    if (acc) begin
      if (idle) begin
        total++;
        bad++;
        $display("FAIL extra_req act=accept req=none");
      end else begin
        it = exp_q.pop_front();
        if (it.hdr) hdr_log.push_back(bus.dma_wr_req_pd[AW-1:0]);
        else dat_acc_cnt++;
        if (it.last_cube) exp_cd = 1;
      end
    end
    if (op_load && idle) begin
      m_cur  = base;
      m_base = base;
    end
    if (cpop) begin
      c  = bus.cmd_fifo_rd_pd;
      sz = c[12:0];
      exp_q.push_back('{1'b1, {{(DW-13-AW){1'b0}}, sz, m_cur}, 1'b0});
      for (int i = 0; i <= int'(sz); i++)
        exp_q.push_back('{1'b0, '0, c[14] && (i == int'(sz))});
      if (c[14]) begin
      end else if (c[13]) begin
        m_base = m_base + stride;
        m_cur  = m_base;
      end else begin
        m_cur = m_cur + (AW'(sz) + 1) * 32;
      end
    end
    f_cmd = cpop;
    f_dat = dpop;
  endtask

  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
    if (f_cmd) void'(cmd_q.pop_front());
    if (f_dat) void'(dat_q.pop_front());
    drive();
  endtask

  task automatic drain();
    int n = 0;
    do begin
      step();
      n++;
    end while ((cmd_q.size() != 0 || exp_q.size() != 0) && n < 30000);
    step();
    if (n >= 30000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout act=%0d req=<30000", n);
    end
  endtask

  task automatic load(logic [AW-1:0] a);
    base = a;
    op_load = 1'b1;
    step();
    op_load = 1'b0;
  endtask

  task automatic outputs_zero(string tag);
    chk1({tag, "_cmd_prdy"}, bus.cmd_fifo_rd_prdy, 1'b0);
    chk1({tag, "_dat_prdy"}, bus.dat_fifo_rd_prdy, 1'b0);
    chk1({tag, "_req_pvld"}, bus.dma_wr_req_pvld, 1'b0);
    chk1({tag, "_req_type"}, bus.dma_wr_req_type, 1'b0);
    chkw({tag, "_req_pd"}, bus.dma_wr_req_pd, '0);
    chk1({tag, "_cube_done"}, cube_done, 1'b0);
  endtask

  initial begin
    int n;
    drive();
    repeat (3) @(posedge clk);
    #1;
    outputs_zero("reset");
    rstn = 1'b1;
    step();
    settled = 1;

    // basic header/data sequencing and address advance
    load(64'h1000);
    hdr_log.delete();
    add_cmd(3, 0, 0);
    add_cmd(0, 0, 0);
    drive();
    drain();
    chka("t1_hdr0", hdr_log[0], 64'h1000);
    chka("t1_hdr1", hdr_log[1], 64'h1080);

    // line end uses the stride
    stride = 64'h400;
    load(64'h1000);
    hdr_log.delete();
    add_cmd(1, 1, 0);
    add_cmd(0, 0, 0);
    drive();
    drain();
    chka("t2_hdr0", hdr_log[0], 64'h1000);
    chka("t2_hdr1", hdr_log[1], 64'h1400);

    // cube end: one pulse, address held until reload
    load(64'h2000);
    hdr_log.delete();
    cd_cnt = 0;
    add_cmd(0, 0, 1);
    add_cmd(2, 0, 0);
    drive();
    drain();
    load(64'h3000);
    add_cmd(0, 0, 0);
    drive();
    drain();
    chka("t3_hdr0", hdr_log[0], 64'h2000);
    chka("t3_hdr1", hdr_log[1], 64'h2000);
    chka("t3_hdr2", hdr_log[2], 64'h3000);
    chka("t3_cube_done_cnt", AW'(cd_cnt), 64'd1);

    // random stalls
    stall = 1;
    load(64'h10000);
    hdr_log.delete();
    for (int i = 0; i < 100; i++)
      add_cmd(int'($urandom_range(7)), 1'($urandom_range(1)),
              $urandom_range(9) == 0);
    drive();
    drain();
    stall = 0;
    drive();
    chka("t4_hdr_cnt", AW'(hdr_log.size()), 64'd100);
    chka("t4_dat_left", AW'(dat_q.size()), 64'd0);

    // maximum size command
    load(64'h0);
    hdr_log.delete();
    add_cmd(8191, 0, 0);
    add_cmd(0, 0, 0);
    drive();
    drain();
    chka("max_hdr1", hdr_log[1], 64'h40000);

    // reset in the middle of a data phase
    load(64'h5000);
    add_cmd(3, 0, 0);
    drive();
    dat_acc_cnt = 0;
    n = 0;
    while (dat_acc_cnt < 2 && n < 100) begin
      step();
      n++;
    end
    chka("t5_beats_before_rst", AW'(dat_acc_cnt), 64'd2);
    rstn = 1'b0;
    #1;
    outputs_zero("t5_rst");
    cmd_q.delete();
    dat_q.delete();
    exp_q.delete();
    exp_cd = 0;
    settled = 0;
    m_cur = '0;
    m_base = '0;
    drive();
    repeat (2) step();
    rstn = 1'b1;
    step();
    settled = 1;
    hdr_log.delete();
    add_cmd(0, 0, 0);
    drive();
    drain();
    chka("t5_hdr0", hdr_log[0], 64'h0);

    // load coinciding with a pop, then address wrap
    hdr_log.delete();
    add_cmd(1, 0, 0);
    drive();
    load(64'hFFFF_FFFF_FFFF_FFE0);
    add_cmd(0, 0, 0);
    drive();
    drain();
    chka("t6_hdr0", hdr_log[0], 64'hFFFF_FFFF_FFFF_FFE0);
    chka("t6_hdr1", hdr_log[1], 64'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
